// File: rtl/filter_pkg.sv
// Shared types and constants for the filter engine scheduler.
// Frame lengths, delta-shift encodings and the completed-frame counter width live here.
package filter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSample,
        StInterp,
        StFinish
    } state_e;

    localparam int unsigned FRAME_M0 = 2;
    localparam int unsigned FRAME_M1 = 4;

    // Cycles spent in StInterp for a long frame; both frames share one StSample and one StFinish.
    localparam int unsigned INTERP_CYC = FRAME_M1 - FRAME_M0;

    localparam logic [1:0] DSH_NONE = 2'd0;
    localparam logic [1:0] DSH_M0   = 2'd1;
    localparam logic [1:0] DSH_M1   = 2'd2;

    localparam int unsigned FCNT_W = 16;

endpackage

// File: rtl/filter_sched_if.sv
// Channel-side request/ack bus and engine control strobes of the filter scheduler.
// The slave modport is the scheduler; the master modport is the channel/engine side.
interface filter_sched_if
    import filter_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned SELW = $clog2(NCH)
) ();

    logic [NCH-1:0]    req;
    logic [NCH-1:0]    mode;
    logic [NCH-1:0]    ack;
    logic [SELW-1:0]   dp_sel;
    logic              dp_sample;
    logic              dp_interp;
    logic              dp_shift;
    logic [1:0]        dp_dsh;
    logic              busy;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        output req, mode,
        input  ack, dp_sel, dp_sample, dp_interp, dp_shift, dp_dsh, busy, frame_cnt
    );

    modport slave (
        input  req, mode,
        output ack, dp_sel, dp_sample, dp_interp, dp_shift, dp_dsh, busy, frame_cnt
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from the channel after ptr, wrapping,
// skipping masked channels. The pointer register is owned by the parent.
module rr_arbiter #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [NCH-1:0]  mask,
    input  logic [SELW-1:0] ptr,
    output logic            valid,
    output logic [SELW-1:0] grant
);

    logic [SELW-1:0] idx;

    // Walk from the farthest candidate back to the nearest so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = NCH; k > 0; k--) begin
            idx = SELW'((int'(ptr) + k) % int'(NCH));
            if (req[idx] && !mask[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/filter_sched.sv
// Round-robin scheduler time-sharing one interpolating FIR engine among NCH channels.
// One frame per grant: sample, optional interpolation steps, then a finishing interp+shift+ack.
module filter_sched
    import filter_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned SELW = $clog2(NCH)
) (
    input logic         Clock,
    input logic         reset,
    filter_sched_if.slave bus
);

    state_e            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic              mode_q, mode_d;
    logic              icnt_q, icnt_d;
    logic [FCNT_W-1:0] cnt_q, cnt_d;

    logic              arb_valid;
    logic [SELW-1:0]   arb_grant;
    logic [NCH-1:0]    arb_mask;
    logic [NCH-1:0]    cur_onehot;

    assign cur_onehot = NCH'(1) << ptr_q;
    // The finishing channel sits out the arbitration that picks its successor.
    assign arb_mask   = (state_q == StFinish) ? cur_onehot : '0;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_arb (
        .req   (bus.req),
        .mask  (arb_mask),
        .ptr   (ptr_q),
        .valid (arb_valid),
        .grant (arb_grant)
    );

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            mode_q  <= 1'b0;
            icnt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            icnt_q  <= icnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
        icnt_d  = icnt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StSample;
                    ptr_d   = arb_grant;
                    mode_d  = bus.mode[arb_grant];
                end
            end
            StSample: begin
                icnt_d  = 1'b0;
                state_d = mode_q ? StInterp : StFinish;
            end
            StInterp: begin
                if (icnt_q == 1'(INTERP_CYC - 1)) begin
                    state_d = StFinish;
                end else begin
                    icnt_d = icnt_q + 1'b1;
                end
            end
            StFinish: begin
                cnt_d = cnt_q + 1'b1;
                if (arb_valid) begin
                    state_d = StSample;
                    ptr_d   = arb_grant;
                    mode_d  = bus.mode[arb_grant];
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The RR pointer doubles as dp_sel: both hold the last granted channel.
    always_comb begin
        bus.busy      = (state_q != StIdle);
        bus.dp_sample = (state_q == StSample);
        bus.dp_interp = (state_q == StInterp) || (state_q == StFinish);
        bus.dp_shift  = (state_q == StFinish);
        bus.ack       = (state_q == StFinish) ? cur_onehot : '0;
        bus.dp_sel    = ptr_q;
        bus.dp_dsh    = (state_q == StIdle) ? DSH_NONE : (mode_q ? DSH_M1 : DSH_M0);
        bus.frame_cnt = cnt_q;
    end

endmodule

// File: tb/tb_filter_sched.sv
// Self-checking bench for filter_sched: directed scenarios plus randomized traffic
// compared against a frame-level reference model.
module tb_filter_sched;
    import filter_pkg::*;

    localparam int NCH = 4;

    logic Clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    filter_sched_if #(.NCH(NCH)) bus ();

    filter_sched #(.NCH(NCH)) dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // {busy, sample, interp, shift, ack[3:0], sel[1:0], dsh[1:0], frame_cnt[15:0]}
    wire logic [27:0] obs = {bus.busy, bus.dp_sample, bus.dp_interp, bus.dp_shift, bus.ack,
                             bus.dp_sel, bus.dp_dsh, bus.frame_cnt};
    // dp_dsh only carries meaning while a frame is running
    wire logic [27:0] obs_cmp = bus.busy ? obs : {obs[27:18], 2'b00, obs[15:0]};

    function automatic logic [27:0] ev(input bit b, input bit s, input bit i, input bit sh,
                                       input logic [3:0] a, input logic [1:0] sel,
                                       input logic [1:0] dsh, input logic [15:0] cnt);
        return {b, s, i, sh, a, sel, dsh, cnt};
    endfunction

    // Reference model: a frame is a channel plus a cycle position within its length.
    int          m_busy, m_chan, m_len, m_pos, m_ptr;
    logic [15:0] m_cnt;

    task automatic m_reset();
        m_busy = 0; m_chan = 0; m_len = 2; m_pos = 0; m_ptr = 0; m_cnt = '0;
    endtask

    function automatic int m_pick(input logic [3:0] r, input int excl);
        for (int k = 1; k <= NCH; k++) begin
            int c = (m_ptr + k) % NCH;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic m_step(input logic [3:0] r, input logic [3:0] md);
        int w;
        if (m_busy != 0 && m_pos < m_len - 1) begin
            m_pos++;
        end else begin
            if (m_busy != 0) m_cnt = m_cnt + 16'd1;
            w = m_pick(r, (m_busy != 0) ? m_chan : -1);
            if (w >= 0) begin
                m_busy = 1; m_chan = w; m_ptr = w; m_pos = 0;
                m_len = md[w] ? FRAME_M1 : FRAME_M0;
            end else begin
                m_busy = 0;
            end
        end
    endtask

    function automatic logic [27:0] m_exp();
        bit last = (m_busy != 0) && (m_pos == m_len - 1);
        return ev(m_busy != 0, (m_busy != 0) && m_pos == 0, (m_busy != 0) && m_pos > 0, last,
                  last ? 4'(1 << m_chan) : 4'd0, 2'(m_chan),
                  (m_busy != 0) ? ((m_len == FRAME_M1) ? 2'd2 : 2'd1) : 2'd0, m_cnt);
    endfunction

    task automatic pulse_reset();
        @(negedge Clock);
        reset = 1'b0;
        @(negedge Clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [27:0] e;
        bus.req = '0; bus.mode = '0;
        #2 reset = 1'b0;
        @(negedge Clock);
        e = '0;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_state: got %h expected %h", obs, e); end
        reset = 1'b1;
    endtask

    task automatic test_single_m0();
        logic [27:0] e;
        bus.req = 4'b0001; bus.mode = 4'b0000;
        @(negedge Clock);
        e = ev(1, 1, 0, 0, 4'b0000, 2'd0, 2'd1, 16'd0);
        checks++;
        if (obs_cmp !== e) begin errors++; $display("FAIL m0_sample: got %h expected %h", obs_cmp, e); end
        bus.req = '0;
        @(negedge Clock);
        e = ev(1, 0, 1, 1, 4'b0001, 2'd0, 2'd1, 16'd0);
        checks++;
        if (obs_cmp !== e) begin errors++; $display("FAIL m0_finish: got %h expected %h", obs_cmp, e); end
        @(negedge Clock);
        e = ev(0, 0, 0, 0, 4'b0000, 2'd0, 2'd0, 16'd1);
        checks++;
        if (obs_cmp !== e) begin errors++; $display("FAIL m0_idle: got %h expected %h", obs_cmp, e); end
    endtask

    task automatic test_single_m1();
        logic [27:0] e;
        bus.req = 4'b0010; bus.mode = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            bus.req = '0;
            if (k == 0)      e = ev(1, 1, 0, 0, 4'b0000, 2'd1, 2'd2, 16'd1);
            else if (k < 3)  e = ev(1, 0, 1, 0, 4'b0000, 2'd1, 2'd2, 16'd1);
            else if (k == 3) e = ev(1, 0, 1, 1, 4'b0010, 2'd1, 2'd2, 16'd1);
            else             e = ev(0, 0, 0, 0, 4'b0000, 2'd1, 2'd0, 16'd2);
            checks++;
            if (obs_cmp !== e) begin
                errors++; $display("FAIL m1_cycle%0d: got %h expected %h", k, obs_cmp, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [27:0] e;
        int ch;
        pulse_reset();
        bus.req = 4'b1111; bus.mode = 4'b0000;
        for (int f = 0; f < 8; f++) begin
            ch = (f + 1) % NCH;
            @(negedge Clock);
            e = ev(1, 1, 0, 0, 4'b0000, 2'(ch), 2'd1, 16'(f));
            checks++;
            if (obs_cmp !== e) begin
                errors++; $display("FAIL b2b_sample%0d: got %h expected %h", f, obs_cmp, e);
            end
            @(negedge Clock);
            e = ev(1, 0, 1, 1, 4'(1 << ch), 2'(ch), 2'd1, 16'(f));
            checks++;
            if (obs_cmp !== e) begin
                errors++; $display("FAIL b2b_finish%0d: got %h expected %h", f, obs_cmp, e);
            end
            if (f == 7) bus.req = '0;
        end
        @(negedge Clock);
        e = ev(0, 0, 0, 0, 4'b0000, 2'd0, 2'd0, 16'd8);
        checks++;
        if (obs_cmp !== e) begin errors++; $display("FAIL b2b_idle: got %h expected %h", obs_cmp, e); end
    endtask

    task automatic test_single_hold();
        logic [27:0] exp_seq [5];
        exp_seq[0] = ev(1, 1, 0, 0, 4'b0000, 2'd2, 2'd1, 16'd8);
        exp_seq[1] = ev(1, 0, 1, 1, 4'b0100, 2'd2, 2'd1, 16'd8);
        exp_seq[2] = ev(0, 0, 0, 0, 4'b0000, 2'd2, 2'd0, 16'd9);
        exp_seq[3] = ev(1, 1, 0, 0, 4'b0000, 2'd2, 2'd1, 16'd9);
        exp_seq[4] = ev(1, 0, 1, 1, 4'b0100, 2'd2, 2'd1, 16'd9);
        bus.req = 4'b0100; bus.mode = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            checks++;
            if (obs_cmp !== exp_seq[k]) begin
                errors++; $display("FAIL hold_cycle%0d: got %h expected %h", k, obs_cmp, exp_seq[k]);
            end
            if (k == 3) bus.req = '0;
        end
        @(negedge Clock);
    endtask

    task automatic test_mode_change();
        logic [27:0] e;
        bus.req = 4'b0001; bus.mode = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            bus.req  = '0;
            bus.mode = 4'(k % 2);
            if (k == 0)      e = ev(1, 1, 0, 0, 4'b0000, 2'd0, 2'd2, 16'd10);
            else if (k < 3)  e = ev(1, 0, 1, 0, 4'b0000, 2'd0, 2'd2, 16'd10);
            else if (k == 3) e = ev(1, 0, 1, 1, 4'b0001, 2'd0, 2'd2, 16'd10);
            else             e = ev(0, 0, 0, 0, 4'b0000, 2'd0, 2'd0, 16'd11);
            checks++;
            if (obs_cmp !== e) begin
                errors++; $display("FAIL modechg_cycle%0d: got %h expected %h", k, obs_cmp, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [27:0] e;
        bus.req = 4'b0001; bus.mode = 4'b0001;
        @(negedge Clock);
        bus.req = '0;
        @(negedge Clock);
        e = ev(1, 0, 1, 0, 4'b0000, 2'd0, 2'd2, 16'd11);
        checks++;
        if (obs_cmp !== e) begin errors++; $display("FAIL rstmid_interp: got %h expected %h", obs_cmp, e); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== 28'd0) begin errors++; $display("FAIL rstmid_async: got %h expected %h", obs, 28'd0); end
        @(negedge Clock);
        checks++;
        if (obs !== 28'd0) begin errors++; $display("FAIL rstmid_held: got %h expected %h", obs, 28'd0); end
        bus.req = 4'b0001; bus.mode = 4'b0000;
        reset = 1'b1;
        @(negedge Clock);
        bus.req = '0;
        e = ev(1, 1, 0, 0, 4'b0000, 2'd0, 2'd1, 16'd0);
        checks++;
        if (obs_cmp !== e) begin errors++; $display("FAIL rstmid_sample: got %h expected %h", obs_cmp, e); end
        @(negedge Clock);
        e = ev(1, 0, 1, 1, 4'b0001, 2'd0, 2'd1, 16'd0);
        checks++;
        if (obs_cmp !== e) begin errors++; $display("FAIL rstmid_finish: got %h expected %h", obs_cmp, e); end
        @(negedge Clock);
    endtask

    task automatic test_wrap();
        int          acks = 0;
        int          cyc  = 0;
        logic [15:0] cnt_at_last = '0;
        pulse_reset();
        bus.req = 4'b0011; bus.mode = 4'b0000;
        while (acks < 65536 && cyc < 140000) begin
            @(negedge Clock);
            cyc++;
            if (bus.ack != '0) begin
                acks++;
                if (acks == 65536) begin
                    cnt_at_last = bus.frame_cnt;
                    bus.req = '0;
                end
            end
        end
        checks++;
        if (acks != 65536) begin errors++; $display("FAIL wrap_acks: got %0d expected 65536", acks); end
        checks++;
        if (cyc != 131072) begin errors++; $display("FAIL wrap_cycles: got %0d expected 131072", cyc); end
        checks++;
        if (cnt_at_last !== 16'hffff) begin
            errors++; $display("FAIL wrap_last_cnt: got %h expected ffff", cnt_at_last);
        end
        @(negedge Clock);
        checks++;
        if (bus.frame_cnt !== 16'd0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL wrap_zero: got cnt %h busy %b expected cnt 0000 busy 0",
                               bus.frame_cnt, bus.busy);
        end
    endtask

    task automatic test_random();
        logic [3:0] r, md;
        pulse_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            md = 4'($urandom_range(0, 15));
            bus.req = r; bus.mode = md;
            m_step(r, md);
            @(negedge Clock);
            checks++;
            if (obs_cmp !== m_exp()) begin
                errors++; $display("FAIL random_cycle%0d: got %h expected %h", c, obs_cmp, m_exp());
            end
        end
        bus.req = '0;
    endtask

    initial begin
        bus.req  = '0;
        bus.mode = '0;
        test_reset();
        test_single_m0();
        test_single_m1();
        test_back_to_back();
        test_single_hold();
        test_mode_change();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
